pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Generic parametrised inter-stage pipeline register for the five-stage CPU, replacing the fixed-field stage latches between decode, execute, memory and writeback. It carries a control bundle and a data bundle with a valid/ready handshake. It supports stall by back-pressure and flush by bubble insertion, and forces control bits to zero whenever the stage holds a bubble. An optional two-entry skid buffer registers the upstream ready path, and a saturating counter reports back-pressure cycles.

## Interface
- DATA_W, 96: data bundle width (e.g. Rs data, Rt data, immediate).
- CTRL_W, 19: control bundle width (WB, M and EX fields packed MSB-first).
- CNT_W, 16: stall counter width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  kill every held entry and any entry accepted this cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage accepts an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream consumes this cycle.
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data bundle; holds its last value when out_valid=0.
- occupancy  out  2  number of held entries: 0..2 with skid, 0..1 without.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid && !out_ready.

## Operation
- Accept: in_valid && in_ready. Drain: out_valid && out_ready.
- Entries leave in acceptance order. No entry is duplicated or dropped except by flush.
- Bubble: a register slot with valid=0 has its ctrl field cleared to 0 on the same edge its valid falls. Data is not cleared.
- Flush has priority over all other events.
  - At the edge where flush=1, every slot becomes invalid, ctrl is zeroed, and any simultaneous accept is discarded.
  - in_ready is unaffected by flush.
- stall_cnt increments by 1 on each edge where out_valid && !out_ready, and saturates at 2^CNT_W-1.
  - stall_cnt is cleared only by reset. Flush does not clear it.
- Reset (asynchronous, mid-operation included): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, all skid state cleared.
  - in_ready is 1 while rst_n=0 with skid disabled, and 0 while rst_n=0 with skid enabled.
  - With skid enabled, in_ready becomes 1 at the first edge after rst_n rises.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 entry per cycle when out_ready is held at 1.
- Simultaneous accept and drain with the main slot full: the new entry replaces the main slot, occupancy is unchanged.
- Without skid:
  - in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
- With skid:
  - in_ready = !skid_valid. This is a register output with no combinational path from out_ready.
  - Accept while the main slot is full and not draining: the entry goes to the skid slot, occupancy=2, and in_ready falls after that edge.
  - Drain while the skid slot is full: skid moves to main on the same edge, and in_ready rises after that edge.
  - Accept and drain on the same edge with the skid slot full cannot occur, because in_ready=0.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-slot storage (main plus skid) and registered in_ready. occupancy reaches 2. A full-throughput stream still sees no bubbles.
- PIPE_STAGE_SKID_EN undefined: single slot and combinational in_ready. occupancy[1] is tied to 0. Behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg holds:
  - WB_W=2, M_W=2 and EX_W=15 field widths.
  - The bit positions of RegWrite, MemtoReg, MemWrite, MemRead, RegDst and ALUSrc inside the ctrl bundle.
  - A default CTRL_W = WB_W+M_W+EX_W.
- Sub-module pipe_slot: one storage entry (valid, ctrl, data) with load, clear and bubble-zeroing. It is instantiated once without skid and twice with skid.

## Test plan
- Reset mid-stream: hold out_ready=0 with occupancy=2, pull rst_n low between edges -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0 immediately.
- Streaming: 8 back-to-back entries with data=i, ctrl=i+1, out_ready=1 -> out_data = 0..7 on consecutive cycles after 1 cycle of latency, in_ready constantly 1.
- Back-pressure (skid): out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 entries accepted, in_ready=0 after the second, stall_cnt=4 or 5 matching cycles observed; release -> entries drain in order.
- Flush with accept: flush=1 and in_valid=1 on the same edge with occupancy=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; the flushed entry never appears.
- Saturation: CNT_W=4, out_valid with out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Build without PIPE_STAGE_SKID_EN: the same streaming test passes, and in_ready tracks out_ready combinationally when full.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the five-stage CPU inter-stage pipeline registers.
// The control bundle is packed MSB-first as {WB, M, EX}:
//   [18:17] WB : RegWrite, MemtoReg
//   [16:15] M  : MemRead, MemWrite
//   [14:0]  EX : RegDst, ALUSrc, then ALU operation / forwarding selects
// No ports (package only).
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 2;
    localparam int EX_W = 15;

    localparam int CTRL_W_DEFAULT = WB_W + M_W + EX_W;
    localparam int DATA_W_DEFAULT = 96;
    localparam int CNT_W_DEFAULT  = 16;

    // Field base positions inside the ctrl bundle.
    localparam int EX_LSB = 0;
    localparam int M_LSB  = EX_LSB + EX_W;
    localparam int WB_LSB = M_LSB + M_W;

    // Individual control bits.
    localparam int REGWRITE_BIT = WB_LSB + 1;
    localparam int MEMTOREG_BIT = WB_LSB + 0;
    localparam int MEMREAD_BIT  = M_LSB + 1;
    localparam int MEMWRITE_BIT = M_LSB + 0;
    localparam int REGDST_BIT   = EX_LSB + EX_W - 1;
    localparam int ALUSRC_BIT   = EX_LSB + EX_W - 2;

    // Number of held entries from the two slot valid bits.
    function automatic logic [1:0] slot_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One pipeline storage entry (valid, ctrl, data).
// Priority: clear > load > unload. Whenever the slot becomes a bubble
// (clear or unload) its ctrl field is zeroed on the same edge; data holds.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               invalidate the slot (flush)
//   load                capture ld_ctrl / ld_data and mark valid
//   unload              entry consumed; slot becomes a bubble
//   ld_ctrl, ld_data    values captured on load
//   valid, ctrl, data   slot contents
// -----------------------------------------------------------------------------
module pipe_slot #(
    parameter int CTRL_W = 19,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              unload,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // NOTE: state registers use non-blocking assignments so every slot
    // samples the pre-edge values of its neighbours (skid -> main transfer).
    // NOTE: data is reset as well because the stage must present out_data=0
    // during reset; this is a single entry, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ld_ctrl;
            data  <= ld_data;
        end else if (unload) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic inter-stage pipeline register with valid/ready handshake, flush by
// bubble insertion, ctrl zeroing on bubbles and a saturating stall counter.
// Build option: define PIPE_STAGE_SKID_EN for a two-slot (main + skid)
// version with a registered in_ready; otherwise a single slot with
// in_ready = !out_valid || out_ready.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   flush                        kill held entries and any accept this cycle
//   in_valid/in_ready            upstream handshake
//   in_ctrl/in_data              upstream bundles
//   out_valid/out_ready          downstream handshake
//   out_ctrl/out_data            held bundles (ctrl zero when out_valid=0)
//   occupancy                    held entries (0..2 with skid, 0..1 without)
//   stall_cnt                    saturating count of out_valid && !out_ready
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic accept;
    logic drain;
    logic main_valid;

    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;
    assign out_valid = main_valid;

`ifdef PIPE_STAGE_SKID_EN

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              main_load;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic [DATA_W-1:0] main_ld_data;
    logic              ready_q;

    // NOTE: every signal in this block is given a value on every path, so
    // no latch is inferred.
    always_comb begin
        skid_load    = 1'b0;
        main_load    = 1'b0;
        main_ld_ctrl = in_ctrl;
        main_ld_data = in_data;
        if (skid_valid) begin
            // in_ready is low, so nothing is accepted; a drain promotes skid.
            main_load    = drain;
            main_ld_ctrl = skid_ctrl;
            main_ld_data = skid_data;
        end else begin
            main_load = accept && (!main_valid || drain);
            skid_load = accept && main_valid && !drain;
        end
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .load    (main_load),
        .unload  (drain),
        .ld_ctrl (main_ld_ctrl),
        .ld_data (main_ld_data),
        .valid   (main_valid),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .load    (skid_load),
        .unload  (drain),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );

    // Registered ready: mirrors the next-state of !skid_valid. Reset holds it
    // low so upstream sees ready only from the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else if (flush) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= !(skid_load || (skid_valid && !drain));
        end
    end

    assign in_ready  = ready_q;
    assign occupancy = slot_count(main_valid, skid_valid);

`else

    // Combinational path from out_ready: a full slot frees as it drains.
    assign in_ready = !main_valid || out_ready;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .load    (accept),
        .unload  (drain),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (main_valid),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

    assign occupancy = slot_count(main_valid, 1'b0);

`endif

    // Back-pressure counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg with a queue-based reference model.
// Works for both builds (PIPE_STAGE_SKID_EN defined or not).
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 19;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    entry_t            sb_q[$];
    int                m_stall;
    logic [DATA_W-1:0] m_last_data;
    bit                m_armed;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check outputs against the
    // model, then advance the model at the rising edge.
    task automatic cycle(input bit fl, input bit iv, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] d, input bit ordy);
        bit exp_ready;
        bit acc;
        bit drn;
        entry_t e;
        flush     = fl;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_ready = SKID ? (m_armed && sb_q.size() < 2) : (sb_q.size() == 0 || ordy);
        check("in_ready",  {127'd0, in_ready}, {127'd0, exp_ready});
        check("out_valid", {127'd0, out_valid}, {127'd0, sb_q.size() != 0});
        check("out_ctrl",  128'(out_ctrl), (sb_q.size() != 0) ? 128'(sb_q[0].ctrl) : 128'd0);
        check("out_data",  128'(out_data), (sb_q.size() != 0) ? 128'(sb_q[0].data) : 128'(m_last_data));
        check("occupancy", 128'(occupancy), 128'(sb_q.size()));
        check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
        @(posedge clk);
        acc = iv && exp_ready;
        drn = (sb_q.size() != 0) && ordy;
        if (sb_q.size() != 0 && !ordy && m_stall != CNT_MAX) m_stall++;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (drn) void'(sb_q.pop_front());
            if (acc) begin
                e.ctrl = c;
                e.data = d;
                sb_q.push_back(e);
            end
        end
        if (sb_q.size() != 0) m_last_data = sb_q[0].data;
        m_armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, ordy);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_ctrl",  128'(out_ctrl), 128'd0);
        check("rst_out_data",  128'(out_data), 128'd0);
        check("rst_occupancy", 128'(occupancy), 128'd0);
        check("rst_stall_cnt", 128'(stall_cnt), 128'd0);
        check("rst_in_ready",  {127'd0, in_ready}, SKID ? 128'd0 : 128'd1);
        sb_q.delete();
        m_stall     = 0;
        m_last_data = '0;
        m_armed     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        async_reset();
        idle(1, 1'b1);

        // Streaming: 8 back-to-back entries, out_ready held high.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, CTRL_W'(i + 1), DATA_W'(i), 1'b1);
        idle(2, 1'b1);

        // Back-pressure: in_valid high, out_ready low for 5 cycles, then drain.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, CTRL_W'(32 + i), DATA_W'(100 + i), 1'b0);
        idle(3, 1'b1);

        // in_ready while full: follows out_ready combinationally without skid,
        // stays registered high (skid slot empty) with skid.
        cycle(1'b0, 1'b1, CTRL_W'(7), DATA_W'(200), 1'b0);
        out_ready = 1'b0;
        #1;
        check("ready_full_hold", {127'd0, in_ready}, SKID ? 128'd1 : 128'd0);
        out_ready = 1'b1;
        #1;
        check("ready_full_drain", {127'd0, in_ready}, 128'd1);
        idle(2, 1'b1);

        // Flush with accept: occupancy=1, flush and in_valid on the same edge.
        cycle(1'b0, 1'b1, CTRL_W'(9), DATA_W'(300), 1'b0);
        cycle(1'b1, 1'b1, CTRL_W'(10), DATA_W'(301), 1'b1);
        idle(2, 1'b1);

        // Saturation: one entry held for 20 cycles, then flush keeps the count.
        cycle(1'b0, 1'b1, CTRL_W'(11), DATA_W'(400), 1'b0);
        idle(20, 1'b0);
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        idle(2, 1'b1);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            cycle(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
                  CTRL_W'($urandom), {$urandom, $urandom, $urandom},
                  ($urandom_range(0, 3) != 0));
        end
        idle(3, 1'b1);

        // Reset mid-stream with out_ready low and the stage full.
        cycle(1'b0, 1'b1, CTRL_W'(21), DATA_W'(500), 1'b0);
        cycle(1'b0, 1'b1, CTRL_W'(22), DATA_W'(501), 1'b0);
        cycle(1'b0, 1'b1, CTRL_W'(23), DATA_W'(502), 1'b0);
        async_reset();
        idle(1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, CTRL_W'(i + 40), DATA_W'(i + 600), 1'b1);
        idle(2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
